// File: rtl/ps2_tx_if.sv
// Command-byte handshake plus PS/2 pin levels and open-drain enables for the ps2_tx host transmitter.
// The slave modport is the transmitter; the master modport is the block that feeds it and owns the pins.
interface ps2_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error
    );
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 11 device clocks, ack check; PS2_TX_RETRY_EN adds one retry.
// Takes one byte per accept, about INHIBIT_CYCLES plus 11 device clocks; tx_ready is low while busy and requests are not queued.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input logic     clk,
    input logic     rst,
    ps2_tx_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_SEND      = 3'd4;
    localparam logic [2:0] S_ACK       = 3'd5;
    localparam logic [2:0] S_WAIT_IDLE = 3'd6;

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1_q, clk_s1_d;
    logic          clk_s2_q, clk_s2_d;
    logic          clk_h_q,  clk_h_d;
    logic          dat_s1_q, dat_s1_d;
    logic          dat_s2_q, dat_s2_d;
    logic [2:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    frame_q,  frame_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q,   done_d;
    logic          error_q,  error_d;
`ifdef PS2_TX_RETRY_EN
    logic          retry_q,  retry_d;
`endif

    logic fall;
    logic line_idle;
    logic timed;
    logic accept;
    logic fail;
    logic tx_ready;

    always_comb begin
        clk_s1_d = bus.ps2_clk_i;
        clk_s2_d = clk_s1_q;
        clk_h_d  = clk_s2_q;
        dat_s1_d = bus.ps2_data_i;
        dat_s2_d = dat_s1_q;
    end

    assign fall      = clk_h_q & ~clk_s2_q;
    assign line_idle = clk_s2_q & dat_s2_q;
    assign tx_ready  = (state_q == S_IDLE) & ~done_q & ~error_q;
    assign accept    = bus.tx_valid & tx_ready;
    assign timed     = (state_q == S_RELEASE) || (state_q == S_SEND) ||
                       (state_q == S_ACK)     || (state_q == S_WAIT_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif

        if (timed) begin
            cnt_d = fall ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (accept) begin
                    // Stop, odd parity, then data; transmitted LSB first.
                    frame_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
                    bit_cnt_d = 4'd0;
                    cnt_d     = '0;
                    state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (fall) begin
                    data_oe_d = ~frame_q[0];
                    bit_cnt_d = 4'd1;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (fall) begin
                    data_oe_d = ~frame_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (!dat_s2_q) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (line_idle) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                data_oe_d = 1'b0;
            end
        endcase

        // A device that released the lines in the same cycle still counts as a success.
        if (timed && !fall && (cnt_q == TO_LAST) && !(state_q == S_WAIT_IDLE && line_idle)) begin
            fail = 1'b1;
        end

        if (fail) begin
            data_oe_d = 1'b0;
            cnt_d     = '0;
            bit_cnt_d = 4'd0;
            done_d    = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                state_d = S_INHIBIT;
            end else begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end
`else
            error_d = 1'b1;
            state_d = S_IDLE;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_h_q   <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= 4'd0;
            frame_q   <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            clk_s1_q  <= clk_s1_d;
            clk_s2_q  <= clk_s2_d;
            clk_h_q   <= clk_h_d;
            dat_s1_q  <= dat_s1_d;
            dat_s2_q  <= dat_s2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    // Clock drive is decoded from state so an async reset releases it at once.
    assign bus.ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.tx_ready    = tx_ready;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.error       = error_q;
endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: behavioural PS/2 device on wired-AND lines, directed sends, scoreboard of expected done/error results.
module tb_ps2_tx;
    localparam int INH  = 10;
    localparam int TO   = 200;
    localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int NF_FAIL = 2;
`else
    localparam int NF_FAIL = 1;
`endif

    typedef struct {
        int         kind;
        logic [7:0] dat;
        logic       par;
        bit         to_chk;
    } exp_t;

    typedef struct {
        logic [7:0] dat;
        int         mode;
        int         kind;
        logic       par;
        bit         to_chk;
        int         frames;
    } vec_t;

    logic clk;
    logic rst;
    logic dev_clk_low;
    logic dev_data_low;
    int   dev_mode;
    int   dev_frames;
    int   dev_falls;
    logic [7:0] dev_byte;
    logic dev_par;
    logic dev_start;
    logic dev_stop;
    int   rel_cnt;
    int   rel_cyc;
    int   cyc;
    int   n_results;
    int   total;
    int   bad;
    exp_t exp_q[$];

    ps2_tx_if ifc ();

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    assign ifc.ps2_clk_i  = ~ifc.ps2_clk_oe  & ~dev_clk_low;
    assign ifc.ps2_data_i = ~ifc.ps2_data_oe & ~dev_data_low;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device: answers each host release with 10 clocks (sampling on rising edges) and an ack clock.
    initial begin
        int   rel_done;
        int   m;
        bit   abort;
        logic [9:0] bits;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        dev_frames = 0; dev_falls = 0; rel_done = 0;
        dev_byte = 8'h00; dev_par = 1'b0; dev_start = 1'b1; dev_stop = 1'b0;
        forever begin
            do @(negedge clk); while (rel_cnt == rel_done);
            rel_done = rel_cnt;
            m = dev_mode;
            dev_frames++;
            dev_falls = 0;
            if (m != 2) begin
                dev_start = ifc.ps2_data_i;
                abort = 1'b0;
                bits  = '0;
                for (int k = 0; k < 10 && !abort; k++) begin
                    wait_clk(HALF);
                    dev_clk_low = 1'b1;
                    dev_falls++;
                    wait_clk(HALF);
                    dev_clk_low = 1'b0;
                    bits[k] = ifc.ps2_data_i;
                    if (m == 3 && k == 4) abort = 1'b1;
                end
                if (!abort) begin
                    dev_byte = bits[7:0];
                    dev_par  = bits[8];
                    dev_stop = bits[9];
                    wait_clk(2);
                    if (m == 0) dev_data_low = 1'b1;
                    wait_clk(HALF - 2);
                    dev_clk_low = 1'b1;
                    dev_falls++;
                    wait_clk(HALF);
                    dev_clk_low = 1'b0;
                    wait_clk(5);
                    dev_data_low = 1'b0;
                end
            end
        end
    end

    // Monitor: release-entry tracking, inhibit length, and scoreboard pops on done/error.
    initial begin
        int   inh_len;
        logic prev_clk_oe;
        bit   pend_rdy;
        exp_t e;
        inh_len = 0; prev_clk_oe = 1'b0; pend_rdy = 1'b0;
        rel_cnt = 0; rel_cyc = 0; n_results = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                inh_len = 0; pend_rdy = 1'b0; prev_clk_oe = 1'b0;
            end else begin
                if (ifc.ps2_clk_oe && !ifc.ps2_data_oe) begin
                    inh_len++;
                end else if (inh_len != 0) begin
                    chk("inhibit_len", inh_len, INH);
                    inh_len = 0;
                end
                if (prev_clk_oe && !ifc.ps2_clk_oe && ifc.ps2_data_oe) begin
                    rel_cnt++;
                    rel_cyc = cyc;
                end
                if (pend_rdy) begin
                    chk("ready_after_result", int'(ifc.tx_ready), 1);
                    pend_rdy = 1'b0;
                end
                if (ifc.done || ifc.error) begin
                    chk("done_error_exclusive", int'(ifc.done && ifc.error), 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_kind", ifc.done ? 0 : 1, e.kind);
                        chk("busy_at_result", int'(ifc.busy), 0);
                        chk("ready_at_result", int'(ifc.tx_ready), 0);
                        if (ifc.done) begin
                            chk("dev_byte", int'(dev_byte), int'(e.dat));
                            chk("dev_parity", int'(dev_par), int'(e.par));
                            chk("dev_start", int'(dev_start), 0);
                            chk("dev_stop", int'(dev_stop), 1);
                        end else begin
                            chk("clk_oe_at_error", int'(ifc.ps2_clk_oe), 0);
                            chk("data_oe_at_error", int'(ifc.ps2_data_oe), 0);
                            if (e.to_chk) begin
                                total++;
                                if ((cyc - rel_cyc) < TO - 3 || (cyc - rel_cyc) > TO + 3) begin
                                    bad++;
                                    $display("FAIL timeout_latency: got %0d expected %0d+-3", cyc - rel_cyc, TO);
                                end
                            end
                        end
                    end
                    pend_rdy = 1'b1;
                    n_results++;
                end
                prev_clk_oe = ifc.ps2_clk_oe;
            end
        end
    end

    task automatic send(input logic [7:0] b, input int mode);
        dev_mode = mode;
        @(negedge clk);
        ifc.tx_data  = b;
        ifc.tx_valid = 1'b1;
        @(negedge clk);
        ifc.tx_valid = 1'b0;
        chk("accepted_busy", int'(ifc.busy), 1);
    endtask

    task automatic wait_res(input int target);
        int n;
        n = 0;
        while (n_results < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("result_in_time", (n_results >= target) ? 1 : 0, 1);
    endtask

    initial begin
        vec_t vecs[4];
        exp_t e;
        int   f0;
        int   n0;
        int   w;
        total = 0; bad = 0;
        rst = 1'b1; dev_mode = 0;
        ifc.tx_data = 8'h00; ifc.tx_valid = 1'b0;

        // 0xED: bits 1,0,1,1,0,1,1,1 (six ones) -> odd parity bit 1; 0xF4 has five ones -> 0.
        vecs[0] = '{dat: 8'hED, mode: 0, kind: 0, par: 1'b1, to_chk: 1'b0, frames: 1};
        vecs[1] = '{dat: 8'hF4, mode: 0, kind: 0, par: 1'b0, to_chk: 1'b0, frames: 1};
        vecs[2] = '{dat: 8'hED, mode: 1, kind: 1, par: 1'b1, to_chk: 1'b0, frames: NF_FAIL};
        vecs[3] = '{dat: 8'hF4, mode: 2, kind: 1, par: 1'b0, to_chk: 1'b1, frames: NF_FAIL};

        wait_clk(3);
        chk("rst_tx_ready", int'(ifc.tx_ready), 1);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_done", int'(ifc.done), 0);
        chk("rst_error", int'(ifc.error), 0);
        chk("rst_clk_oe", int'(ifc.ps2_clk_oe), 0);
        chk("rst_data_oe", int'(ifc.ps2_data_oe), 0);
        rst = 1'b0;
        wait_clk(5);

        for (int i = 0; i < 4; i++) begin
            f0 = dev_frames;
            n0 = n_results;
            e = '{kind: vecs[i].kind, dat: vecs[i].dat, par: vecs[i].par, to_chk: vecs[i].to_chk};
            exp_q.push_back(e);
            send(vecs[i].dat, vecs[i].mode);
            wait_res(n0 + 1);
            wait_clk(60);
            chk("frame_count", dev_frames - f0, vecs[i].frames);
        end

        // Reset mid-frame after fall 5: bit 4 of 0xED is 0, so data is being driven low.
        send(8'hED, 3);
        w = 0;
        while (dev_falls < 5 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("reached_fall5", (dev_falls >= 5) ? 1 : 0, 1);
        wait_clk(6);
        chk("bit4_driven", int'(ifc.ps2_data_oe), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_clk_oe", int'(ifc.ps2_clk_oe), 0);
        chk("rst_mid_data_oe", int'(ifc.ps2_data_oe), 0);
        chk("rst_mid_busy", int'(ifc.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(ifc.tx_ready), 1);
        wait_clk(60);

        // 0x55 has four ones -> parity 1.
        n0 = n_results;
        exp_q.push_back('{kind: 0, dat: 8'h55, par: 1'b1, to_chk: 1'b0});
        send(8'h55, 0);
        wait_res(n0 + 1);
        wait_clk(60);

        // A request while busy must be ignored.
        f0 = dev_frames;
        n0 = n_results;
        exp_q.push_back('{kind: 0, dat: 8'hED, par: 1'b1, to_chk: 1'b0});
        send(8'hED, 0);
        wait_clk(100);
        ifc.tx_data  = 8'hAA;
        ifc.tx_valid = 1'b1;
        chk("ready_while_busy", int'(ifc.tx_ready), 0);
        @(negedge clk);
        ifc.tx_valid = 1'b0;
        wait_res(n0 + 1);
        wait_clk(80);
        chk("no_second_frame", dev_frames - f0, 1);
        chk("idle_after_ignore", int'(ifc.busy), 0);
        chk("one_done_only", n_results - n0, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED LED set, 0xF4 enable) to the keyboard over the same open-drain ps2_clk/ps2_data lines the existing PS/2 receive path listens on.
- Runs the full host request sequence: inhibit, request-to-send, 11 device-clocked bits and the ack check. Reports success or failure with one-cycle pulses.
- Sits beside the receiver. The receiver must ignore the lines while busy is high.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max clk cycles between consecutive device falling edges, or from release to the first edge (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock; the single clock.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to send; sampled on accept.
- tx_valid  in  1  send request.
- tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready.
- ps2_clk_i  in  1  raw PS/2 clock pin level (asynchronous).
- ps2_data_i  in  1  raw PS/2 data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release.
- ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse: byte sent and acked.
- error  out  1  one-cycle pulse: NACK or timeout.

Behaviour:
- Reset (async, immediate):
  - state IDLE; tx_ready=1; busy, done, error, ps2_clk_oe, ps2_data_oe all 0; counters 0.
  - Lines are released immediately, including when reset asserts mid-frame.
- Input sampling:
  - ps2_clk_i and ps2_data_i each pass through a 2-FF synchroniser plus one history reg.
  - fall = hist & ~sync on the clock line. Data is sampled from its synchronised copy.
- Frame register on accept:
  - shift = {1'b1 stop, ~^tx_data odd parity, tx_data}, 10 bits, LSB first.
  - bit_cnt=0; go to INHIBIT next cycle.
- States:
  - IDLE: lines released; tx_valid while busy is never accepted (no queueing).
  - INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then REQ.
  - REQ: clk_oe=1 and data_oe=1 for 1 cycle (start bit = 0), then RELEASE.
  - RELEASE: clk_oe=0, data_oe=1; wait for fall. Timeout counter starts at 0 on entry.
  - SEND: on each fall, data_oe <= ~shift[bit_cnt] the next cycle, then bit_cnt++.
    - Falls 1..8 present data bits 0..7, fall 9 presents parity, fall 10 presents stop (released).
    - After fall 10, go to ACK.
  - ACK: on fall 11, sample data. 0 → WAIT_IDLE. 1 → error pulse, IDLE.
  - WAIT_IDLE: wait until synchronised clock and data are both 1 (device released), then done pulse, IDLE.
- Timeout:
  - The counter clears on every fall and counts otherwise in RELEASE, SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: both oe=0, error pulse, IDLE.
- Output rules:
  - done and error are never high in the same cycle.
  - tx_ready rises in the cycle after done or error.
  - data_oe changes at most 1 clk after a detected fall, i.e. ≤4 clk after the pin edge. This is well inside the device's low phase.
  - clk_oe is only ever 1 in INHIBIT and REQ.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined:
  - On NACK or timeout, both lines are released and the FSM restarts at INHIBIT with the latched byte, once. error pulses only if the retry also fails.
  - One retry flag register, cleared on accept.
- Undefined: first failure pulses error and returns to IDLE; no retry logic is synthesised.

Test Plan (bench: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200, behavioural device model with 20-clk half period):
- Send tx_data=0xED with device acking → clk_oe low exactly 10 cycles, start bit 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1, then done pulse once; busy falls with done.
- Send 0xF4 → parity bit 0 on line, device model decodes 0xF4, done=1, error never 1.
- Device leaves data high on ack clock → error pulse, done stays 0, lines released; with PS2_TX_RETRY_EN a second full inhibit/frame occurs before error.
- Device never clocks after release → error exactly 200 cycles (±3 sync) after RELEASE entry, both oe=0.
- Assert rst after fall 5 → clk_oe=data_oe=0 in same cycle, tx_ready=1 after release; next send of 0x55 completes normally.
- Pulse tx_valid with 0xAA while busy during 0xED transfer → ignored; device receives only 0xED, one done.
